// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage pipeline.
// Registers ALU results, store data, destination and controls for the MEM stage.
// Computes the branch decision and target.
// Optional multiplier (opcode 8) is built only when the MUL_EN macro is defined.
// Without MUL_EN, opcode 8 behaves as a NOP and stall_out is tied low.
// Handshake: stall_out is the only flow control. While it is high, upstream holds
// ID/EXE and PC, and this stage pushes bubbles (all controls 0) into its output register.
// FSM state is visible on dbg_state_out (IDLE=0, BUSY=1, DONE=2; 0 when MUL_EN is undefined).

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 16
`endif

module exe_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              branch_in,
    input  logic [`DSIZE-1:0] rdata1_in,
    input  logic [`DSIZE-1:0] rdata2_in1,
    input  logic [`DSIZE-1:0] rdata2_in2,
    input  logic [`DSIZE-1:0] imm_in,
    input  logic [3:0]        opcode_in,
    input  logic [`ASIZE-1:0] waddr_in,
    input  logic [`ISIZE-1:0] nPC_in,
    output logic              stall_out,
    output logic [`DSIZE-1:0] alu_out,
    output logic [`DSIZE-1:0] wdata_out,
    output logic [`ASIZE-1:0] waddr_out,
    output logic              wen_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              mem_to_reg_out,
    output logic              branch_taken_out,
    output logic [`ISIZE-1:0] branch_target_out,
    output logic [1:0]        dbg_state_out
);

    localparam int DW = `DSIZE;
    localparam int AW = `ASIZE;
    localparam int IW = `ISIZE;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_LW  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_BEQ = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;

    // Single-cycle datapath results
    logic [DW-1:0] w_alu;
    logic          w_valid;
    logic          w_is_branch;
    logic          w_taken;
    logic [IW-1:0] w_target;

    // Multiplier-side signals, tied off when the multiplier is not built
    logic          w_stall;
    logic          w_mul_done;
    logic [DW-1:0] w_mul_result;
    logic          w_mul_wen;
    logic          w_mul_rd;
    logic          w_mul_wr;
    logic          w_mul_m2r;
    logic [AW-1:0] w_mul_waddr;

    assign w_target = nPC_in + imm_in[IW-1:0];

    // Decode the opcode and compute the single-cycle result and branch decision
    always_comb begin
        w_alu       = '0;
        w_valid     = 1'b1;
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        case (opcode_in)
            OP_ADD: w_alu = rdata1_in + rdata2_in1;
            OP_SUB: w_alu = rdata1_in - rdata2_in1;
            OP_AND: w_alu = rdata1_in & rdata2_in1;
            OP_OR:  w_alu = rdata1_in | rdata2_in1;
            OP_SLT: w_alu = {{(DW-1){1'b0}}, ($signed(rdata1_in) < $signed(rdata2_in1))};
            OP_SLL: w_alu = rdata1_in << imm_in[3:0];
            OP_SRL: w_alu = rdata1_in >> imm_in[3:0];
            OP_SRA: w_alu = $signed(rdata1_in) >>> imm_in[3:0];
            OP_LW:  w_alu = rdata1_in + imm_in;
            OP_SW:  w_alu = rdata1_in + imm_in;
            OP_BEQ: begin
                w_is_branch = 1'b1;
                w_taken     = branch_in & (rdata1_in == rdata2_in1);
            end
            OP_BNE: begin
                w_is_branch = 1'b1;
                w_taken     = branch_in & (rdata1_in != rdata2_in1);
            end
            // Multiply never completes on this path; the FSM owns it when built
            OP_MUL:  w_valid = 1'b0;
            default: w_valid = 1'b0;
        endcase
    end

`ifdef MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(DW + 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_mcand;
    logic [DW-1:0] r_mplier;
    logic [DW-1:0] r_prod;
    logic          r_m_wen;
    logic          r_m_rd;
    logic          r_m_wr;
    logic          r_m_m2r;
    logic [AW-1:0] r_m_waddr;
    logic          w_mul_start;

    assign w_mul_start   = (r_state == S_IDLE) && (opcode_in == OP_MUL);
    assign w_stall       = w_mul_start || (r_state == S_BUSY);
    assign w_mul_done    = (r_state == S_DONE);
    assign w_mul_result  = r_prod;
    assign w_mul_wen     = r_m_wen;
    assign w_mul_rd      = r_m_rd;
    assign w_mul_wr      = r_m_wr;
    assign w_mul_m2r     = r_m_m2r;
    assign w_mul_waddr   = r_m_waddr;
    assign dbg_state_out = r_state;

    // Shift-add multiplier: latch operands at start, one partial product per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_m_wen   <= 1'b0;
            r_m_rd    <= 1'b0;
            r_m_wr    <= 1'b0;
            r_m_m2r   <= 1'b0;
            r_m_waddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_start) begin
                        r_mcand   <= rdata1_in;
                        r_mplier  <= rdata2_in1;
                        r_prod    <= '0;
                        r_count   <= CW'(DW);
                        r_m_wen   <= wen_in;
                        r_m_rd    <= mem_read_in;
                        r_m_wr    <= mem_write_in;
                        r_m_m2r   <= mem_to_reg_in;
                        r_m_waddr <= waddr_in;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    // The last iteration lands the product; the count reaches zero here
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_stall       = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_result  = '0;
    assign w_mul_wen     = 1'b0;
    assign w_mul_rd      = 1'b0;
    assign w_mul_wr      = 1'b0;
    assign w_mul_m2r     = 1'b0;
    assign w_mul_waddr   = '0;
    assign dbg_state_out = 2'd0;
`endif

    assign stall_out = w_stall;

    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_waddr;
    logic          r_wen;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_mem_to_reg;
    logic          r_taken;
    logic [IW-1:0] r_target;

    // EXE/MEM register: reset, bubble during a multiply, multiply result, or normal result
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_alu        <= '0;
            r_wdata      <= '0;
            r_waddr      <= '0;
            r_wen        <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
        end else if (w_mul_done) begin
            r_alu        <= w_mul_result;
            r_wdata      <= '0;
            r_waddr      <= w_mul_waddr;
            r_wen        <= w_mul_wen;
            r_mem_read   <= w_mul_rd;
            r_mem_write  <= w_mul_wr;
            r_mem_to_reg <= w_mul_m2r;
            r_taken      <= 1'b0;
            r_target     <= '0;
        end else begin
            r_alu        <= w_alu;
            r_wdata      <= w_valid ? rdata2_in2 : '0;
            r_waddr      <= w_valid ? waddr_in : '0;
            r_wen        <= w_valid & ~w_is_branch & wen_in;
            r_mem_read   <= w_valid & mem_read_in;
            r_mem_write  <= w_valid & mem_write_in;
            r_mem_to_reg <= w_valid & mem_to_reg_in;
            r_taken      <= w_taken;
            r_target     <= w_valid ? w_target : '0;
        end
    end

    assign alu_out           = r_alu;
    assign wdata_out         = r_wdata;
    assign waddr_out         = r_waddr;
    assign wen_out           = r_wen;
    assign mem_read_out      = r_mem_read;
    assign mem_write_out     = r_mem_write;
    assign mem_to_reg_out    = r_mem_to_reg;
    assign branch_taken_out  = r_taken;
    assign branch_target_out = r_target;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage.
// The driver issues instructions as a held upstream would.
// Expected output-register contents are queued per clock edge.
// A monitor pops and compares them after each edge.
// Build with MUL_EN defined to exercise the multiplier.
`timescale 1ns/1ps

module tb_exe_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] b2;
        logic [15:0] imm;
        logic [4:0]  wa;
        logic        wen;
        logic        mrd;
        logic        mwr;
        logic        m2r;
        logic        br;
        logic [15:0] npc;
    } instr_t;

    typedef struct packed {
        logic        chk_alu;
        logic        chk_waddr;
        logic        chk_rest;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [4:0]  waddr;
        logic        wen;
        logic        mrd;
        logic        mwr;
        logic        m2r;
        logic        taken;
        logic [15:0] target;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wen_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in;
    logic [15:0] rdata1_in, rdata2_in1, rdata2_in2, imm_in, nPC_in;
    logic [3:0]  opcode_in;
    logic [4:0]  waddr_in;
    logic        stall_out;
    logic [15:0] alu_out, wdata_out, branch_target_out;
    logic [4:0]  waddr_out;
    logic        wen_out, mem_read_out, mem_write_out, mem_to_reg_out, branch_taken_out;
    logic [1:0]  dbg_state_out;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .wen_in(wen_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
        .rdata1_in(rdata1_in), .rdata2_in1(rdata2_in1), .rdata2_in2(rdata2_in2),
        .imm_in(imm_in), .opcode_in(opcode_in), .waddr_in(waddr_in), .nPC_in(nPC_in),
        .stall_out(stall_out), .alu_out(alu_out), .wdata_out(wdata_out),
        .waddr_out(waddr_out), .wen_out(wen_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
        .dbg_state_out(dbg_state_out)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the architectural result of one instruction
    function automatic exp_t model(input instr_t in);
        exp_t e;
        int   sa;
        int   sa_val;
        int   sb_val;
        e = '0;
        sa = int'(in.imm[3:0]);
        sa_val = int'($signed(in.a));
        sb_val = int'($signed(in.b));
        e.chk_alu = 1'b1; e.chk_waddr = 1'b1; e.chk_rest = 1'b1;
        e.waddr = in.wa; e.wdata = in.b2; e.target = in.npc + in.imm;
        e.wen = in.wen; e.mrd = in.mrd; e.mwr = in.mwr; e.m2r = in.m2r;
        case (in.op)
            4'd0: e.alu = 16'(int'(in.a) + int'(in.b));
            4'd1: e.alu = 16'(int'(in.a) - int'(in.b));
            4'd2: e.alu = in.a & in.b;
            4'd3: e.alu = in.a | in.b;
            4'd4: e.alu = (sa_val < sb_val) ? 16'd1 : 16'd0;
            4'd5: e.alu = 16'(int'(in.a) * (1 << sa));
            4'd6: e.alu = 16'(int'(in.a) / (1 << sa));
            4'd7: e.alu = 16'(sa_val >>> sa);
`ifdef MUL_EN
            4'd8: begin
                e.alu = 16'(int'(in.a) * int'(in.b));
                e.chk_rest = 1'b0;
            end
`endif
            4'd9, 4'd10: e.alu = 16'(int'(in.a) + int'(in.imm));
            4'd11, 4'd12: begin
                e.chk_alu = 1'b0;
                e.wen = 1'b0;
                e.taken = in.br && ((in.op == 4'd11) ? (in.a == in.b) : (in.a != in.b));
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int stall_expect(input logic [3:0] op);
`ifdef MUL_EN
        return (op == 4'd8) ? 17 : 0;
`else
        return (op == 4'd8) ? 0 : 0;
`endif
    endfunction

    exp_t bubble_rec;
    exp_t zero_full;
    initial begin
        bubble_rec = '0;
        zero_full = '0;
        zero_full.chk_alu = 1'b1;
        zero_full.chk_waddr = 1'b1;
        zero_full.chk_rest = 1'b1;
    end

    // Monitor: one queued expectation per clock edge, compared after the edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ctrl", {27'd0, wen_out, mem_read_out, mem_write_out, mem_to_reg_out, branch_taken_out},
                {27'd0, e.wen, e.mrd, e.mwr, e.m2r, e.taken});
            if (e.chk_alu) chk("alu_out", {16'd0, alu_out}, {16'd0, e.alu});
            if (e.chk_waddr) chk("waddr_out", {27'd0, waddr_out}, {27'd0, e.waddr});
            if (e.chk_rest) begin
                chk("wdata_out", {16'd0, wdata_out}, {16'd0, e.wdata});
                chk("branch_target_out", {16'd0, branch_target_out}, {16'd0, e.target});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input instr_t in);
        opcode_in = in.op; rdata1_in = in.a; rdata2_in1 = in.b; rdata2_in2 = in.b2;
        imm_in = in.imm; waddr_in = in.wa; wen_in = in.wen; mem_read_in = in.mrd;
        mem_write_in = in.mwr; mem_to_reg_in = in.m2r; branch_in = in.br; nPC_in = in.npc;
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] imm, input logic [4:0] wa, input logic wen,
                                  input logic br, input logic [15:0] npc);
        instr_t in;
        in = '0;
        in.op = op; in.a = a; in.b = b; in.b2 = 16'hA5A5; in.imm = imm;
        in.wa = wa; in.wen = wen; in.br = br; in.npc = npc;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        in.op  = 4'($urandom_range(0, 15));
        in.a   = 16'($urandom);
        in.b   = ($urandom_range(0, 3) == 0) ? in.a : 16'($urandom);
        in.b2  = 16'($urandom);
        in.imm = 16'($urandom);
        in.wa  = 5'($urandom);
        in.wen = 1'($urandom); in.mrd = 1'($urandom); in.mwr = 1'($urandom);
        in.m2r = 1'($urandom); in.br = 1'($urandom);
        in.npc = 16'($urandom);
        return in;
    endfunction

    // Present one instruction and hold it while stall_out is high
    task automatic issue(input instr_t in);
        int  n_stall;
        bit  accepted;
        n_stall = 0;
        accepted = 1'b0;
        drive(in);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (stall_out) begin
                n_stall++;
                exp_q.push_back(bubble_rec);
                @(posedge clk); #1;
            end else begin
                exp_q.push_back(model(in));
                accepted = 1'b1;
                @(posedge clk); #1;
                break;
            end
        end
        if (!accepted) $display("FAIL accept_timeout: got stall for %0d cycles, required release", n_stall);
        chk("stall_cycles", n_stall, stall_expect(in.op));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(mk(4'd13, 16'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0, 16'd0));
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            exp_q.push_back(zero_full);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        instr_t in;
        do_reset(2);
        @(negedge clk);
        chk("stall_after_reset", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;

        issue(mk(4'd0, 16'h0005, 16'hFFFF, 16'h0000, 5'd3, 1'b1, 1'b0, 16'h0001));
        issue(mk(4'd7, 16'h8000, 16'h0000, 16'h0004, 5'd4, 1'b1, 1'b0, 16'h0002));
        issue(mk(4'd4, 16'hFFFF, 16'h0001, 16'h0000, 5'd5, 1'b1, 1'b0, 16'h0003));
        issue(mk(4'd4, 16'h0001, 16'hFFFF, 16'h0000, 5'd5, 1'b1, 1'b0, 16'h0003));
        issue(mk(4'd11, 16'h0007, 16'h0007, 16'hFFFE, 5'd6, 1'b1, 1'b1, 16'h0010));
        issue(mk(4'd12, 16'h0007, 16'h0007, 16'hFFFE, 5'd6, 1'b1, 1'b1, 16'h0010));
        issue(mk(4'd12, 16'h0007, 16'h0009, 16'h0004, 5'd6, 1'b1, 1'b1, 16'hFFFE));
        in = mk(4'd9, 16'h1000, 16'h0000, 16'hFFF0, 5'd7, 1'b1, 1'b0, 16'h0020);
        in.mrd = 1'b1; in.m2r = 1'b1;
        issue(in);
        in = mk(4'd10, 16'h2000, 16'h0000, 16'h0010, 5'd0, 1'b0, 1'b0, 16'h0021);
        in.mwr = 1'b1; in.b2 = 16'h1234;
        issue(in);
        in = mk(4'd14, 16'h1111, 16'h2222, 16'h0001, 5'd9, 1'b1, 1'b1, 16'h0030);
        in.mrd = 1'b1; in.mwr = 1'b1; in.m2r = 1'b1;
        issue(in);
        issue(mk(4'd8, 16'h0003, 16'h0005, 16'h0000, 5'd8, 1'b1, 1'b0, 16'h0040));
        issue(mk(4'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 5'd9, 1'b1, 1'b0, 16'h0041));
        issue(mk(4'd0, 16'h0010, 16'h0020, 16'h0000, 5'd10, 1'b1, 1'b0, 16'h0042));

        for (int i = 0; i < 120; i++) issue(rand_instr());

`ifdef MUL_EN
        // Reset in the middle of a multiply, then a plain ADD
        drive(mk(4'd8, 16'h1234, 16'h0011, 16'h0000, 5'd11, 1'b1, 1'b0, 16'h0050));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) chk("stall_mul_start", {31'd0, stall_out}, 32'd1);
            exp_q.push_back(bubble_rec);
            @(posedge clk); #1;
        end
        do_reset(1);
        @(negedge clk);
        chk("stall_after_abort", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
`else
        do_reset(1);
`endif
        issue(mk(4'd0, 16'h0005, 16'hFFFF, 16'h0000, 5'd3, 1'b1, 1'b0, 16'h0060));

        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
